multicycle_ctrl: RTL
====================

# multicycle_ctrl

Main control FSM for the multicycle MIPS datapath. It sequences fetch, decode, execute, memory and writeback for each instruction. It drives the register file's `regwrite`, `regdst` and `memtoreg` together with the PC, IR, ALU-mux and memory strobes. It also stalls on a memory ready handshake and counts retired instructions.

## Interface
Parameters:
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `opcode`  in  6  IR[31:26]
- `funct`  in  6  IR[5:0]; accepted but unused for decode, ALU uses it via `aluop`=10
- `zero`  in  1  ALU zero flag
- `mem_ready`  in  1  memory completes the current read/write this cycle
- `pcen`  out  1  PC load enable
- `pcsource`  out  2  00 ALU result, 01 ALUOut, 10 jump target
- `iord`  out  1  0 PC address, 1 ALUOut address
- `memread`  out  1  memory read strobe
- `memwrite`  out  1  memory write strobe
- `irwrite`  out  1  IR load
- `memtoreg`  out  1  regfile din select, 1 = memdata
- `regwrite`  out  1  regfile write enable
- `regdst`  out  1  1 = rd, 0 = rt
- `alusrca`  out  1  0 PC, 1 register A
- `alusrcb`  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- `aluop`  out  2  00 add, 01 sub, 10 funct
- `retire`  out  1  one-cycle pulse on the final cycle of each legal instruction
- `illegal`  out  1  one-cycle pulse on decode of an unsupported opcode
- `instret`  out  CNT_W  count of retired instructions
- `state`  out  4  current state, for debug

## Operation
- Supported opcodes: R-type 0x00, lw 0x23, sw 0x2B, beq 0x04, j 0x02, addi 0x08.
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, REX 6, RWB 7, BRANCH 8, JUMP 9, IEX 10, IWB 11. Codes 12–15 are unreachable and go to FETCH.
- Transitions:
  - FETCH→DECODE when `mem_ready`; otherwise hold.
  - DECODE→MEMADR for lw/sw, REX for R-type, BRANCH for beq, JUMP for j, IEX for addi; any other opcode→FETCH.
  - MEMADR→MEMRD for lw, MEMWR for sw.
  - MEMRD→MEMWB when `mem_ready`; otherwise hold.
  - MEMWR→FETCH when `mem_ready`; otherwise hold.
  - REX→RWB, IEX→IWB.
  - MEMWB, RWB, IWB, BRANCH and JUMP → FETCH.
- Outputs are a Moore decode of `state`. Any output not listed for a state is 0.
  - FETCH: `memread`=1, `alusrcb`=01, `aluop`=00, `pcsource`=00. `irwrite` and `pcen` equal `mem_ready`.
  - DECODE: `alusrcb`=11, `aluop`=00 (branch target into ALUOut).
  - MEMADR: `alusrca`=1, `alusrcb`=10.
  - MEMRD: `memread`=1, `iord`=1.
  - MEMWB: `regwrite`=1, `memtoreg`=1, `regdst`=0.
  - MEMWR: `memwrite`=1, `iord`=1.
  - REX: `alusrca`=1, `aluop`=10.
  - RWB: `regwrite`=1, `regdst`=1.
  - BRANCH: `alusrca`=1, `aluop`=01, `pcsource`=01, `pcen`=`zero`.
  - JUMP: `pcsource`=10, `pcen`=1.
  - IEX: `alusrca`=1, `alusrcb`=10.
  - IWB: `regwrite`=1, `regdst`=0.
- `retire` is 1 in MEMWB, RWB, IWB, BRANCH and JUMP, and in MEMWR when `mem_ready`=1.
- `illegal` is 1 in DECODE when the opcode is unsupported.
- `instret` increments by 1 on every clock edge where `retire`=1, and wraps modulo 2^CNT_W.

## Timing
- Reset: on the edge with `rst`=1, `state` becomes FETCH and `instret` becomes 0.
- While `rst`=1, every control output including `retire` and `illegal` is forced to 0.
- The first fetch happens in the first cycle with `rst`=0.
- Reset mid-instruction abandons the instruction; the partial instruction is not counted.
- Cycles per instruction with `mem_ready` held high: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Each cycle `mem_ready`=0 in FETCH, MEMRD or MEMWR adds exactly one cycle. During the stall the strobes stay asserted and `irwrite`/`pcen` stay 0.
- `mem_ready` is ignored in every other state.
- `regwrite` is high for exactly one cycle per lw, R-type and addi, and never for sw, beq, j or illegal.

## Test plan
- Reset: hold `rst` 3 cycles with `mem_ready`=1 → all outputs 0, `instret`=0. First cycle after release: `state`=0, `memread`=1, `irwrite`=1, `pcen`=1.
- R-type and lw with `mem_ready`=1: op 0x00 → states 0,1,6,7, with `regwrite`=`regdst`=1 in state 7. Then lw 0x23 → states 0,1,2,3,4, with `memtoreg`=1 in state 4. `instret`=2.
- Stalls: sw 0x2B with `mem_ready` low 2 cycles in FETCH and 3 in MEMWR → 9 cycles total. `memwrite` high 4 cycles, `retire` pulses once, `regwrite` never set.
- beq 0x04: with `zero`=1, `pcen`=1 and `pcsource`=01 in state 8. With `zero`=0, `pcen`=0. j 0x02: `pcen`=1, `pcsource`=10.
- Illegal opcode 0x3F: states 0,1,0; `illegal` pulses once in DECODE; `instret` unchanged; no `regwrite`.
- Reset asserted in MEMRD of a lw → next state 0, no `regwrite`, `instret` unchanged by the aborted instruction. Separately, preset `CNT_W`=4 and retire 17 instructions → `instret`=1.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch, decode,
// execute, memory and writeback, stalls on mem_ready and counts retirements.
module multicycle_ctrl #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             pcen,
   output logic [1:0]       pcsource,
   output logic             iord,
   output logic             memread,
   output logic             memwrite,
   output logic             irwrite,
   output logic             memtoreg,
   output logic             regwrite,
   output logic             regdst,
   output logic             alusrca,
   output logic [1:0]       alusrcb,
   output logic [1:0]       aluop,
   output logic             retire,
   output logic             illegal,
   output logic [CNT_W-1:0] instret,
   output logic [3:0]       state
);

   typedef enum logic [3:0] {
      StFetch  = 4'd0,
      StDecode = 4'd1,
      StMemAdr = 4'd2,
      StMemRd  = 4'd3,
      StMemWb  = 4'd4,
      StMemWr  = 4'd5,
      StRex    = 4'd6,
      StRwb    = 4'd7,
      StBranch = 4'd8,
      StJump   = 4'd9,
      StIex    = 4'd10,
      StIwb    = 4'd11
   } state_e;

   localparam logic [5:0] OpRtype = 6'h00;
   localparam logic [5:0] OpLw    = 6'h23;
   localparam logic [5:0] OpSw    = 6'h2B;
   localparam logic [5:0] OpBeq   = 6'h04;
   localparam logic [5:0] OpJ     = 6'h02;
   localparam logic [5:0] OpAddi  = 6'h08;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] instret_q;
   logic             is_legal;

   // funct only matters to the ALU decoder, which sees it when aluop is 10
   logic unused_funct;
   assign unused_funct = ^funct;

   assign is_legal = opcode inside {OpRtype, OpLw, OpSw, OpBeq, OpJ, OpAddi};
   assign state    = state_q;
   assign instret  = instret_q;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StFetch;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; unused encodings 12-15 fall back to fetch
   always_comb begin
      state_d = StFetch;
      case (state_q)
         StFetch:  state_d = mem_ready ? StDecode : StFetch;
         StDecode: begin
            case (opcode)
               OpLw, OpSw: state_d = StMemAdr;
               OpRtype:    state_d = StRex;
               OpBeq:      state_d = StBranch;
               OpJ:        state_d = StJump;
               OpAddi:     state_d = StIex;
               default:    state_d = StFetch;
            endcase
         end
         StMemAdr: state_d = (opcode == OpSw) ? StMemWr : StMemRd;
         StMemRd:  state_d = mem_ready ? StMemWb : StMemRd;
         StMemWr:  state_d = mem_ready ? StFetch : StMemWr;
         StRex:    state_d = StRwb;
         StIex:    state_d = StIwb;
         default:  state_d = StFetch;
      endcase
   end

   // Moore control decode, all forced low while reset is held
   always_comb begin
      pcen     = 1'b0;
      pcsource = 2'b00;
      iord     = 1'b0;
      memread  = 1'b0;
      memwrite = 1'b0;
      irwrite  = 1'b0;
      memtoreg = 1'b0;
      regwrite = 1'b0;
      regdst   = 1'b0;
      alusrca  = 1'b0;
      alusrcb  = 2'b00;
      aluop    = 2'b00;
      retire   = 1'b0;
      illegal  = 1'b0;
      if (!rst) begin
         case (state_q)
            StFetch: begin
               memread = 1'b1;
               alusrcb = 2'b01;
               irwrite = mem_ready;
               pcen    = mem_ready;
            end
            StDecode: begin
               alusrcb = 2'b11;
               illegal = ~is_legal;
            end
            StMemAdr: begin
               alusrca = 1'b1;
               alusrcb = 2'b10;
            end
            StMemRd: begin
               memread = 1'b1;
               iord    = 1'b1;
            end
            StMemWb: begin
               regwrite = 1'b1;
               memtoreg = 1'b1;
               retire   = 1'b1;
            end
            StMemWr: begin
               memwrite = 1'b1;
               iord     = 1'b1;
               retire   = mem_ready;
            end
            StRex: begin
               alusrca = 1'b1;
               aluop   = 2'b10;
            end
            StRwb: begin
               regwrite = 1'b1;
               regdst   = 1'b1;
               retire   = 1'b1;
            end
            StBranch: begin
               alusrca  = 1'b1;
               aluop    = 2'b01;
               pcsource = 2'b01;
               pcen     = zero;
               retire   = 1'b1;
            end
            StJump: begin
               pcsource = 2'b10;
               pcen     = 1'b1;
               retire   = 1'b1;
            end
            StIex: begin
               alusrca = 1'b1;
               alusrcb = 2'b10;
            end
            StIwb: begin
               regwrite = 1'b1;
               retire   = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Retired-instruction counter, wraps naturally at 2^CNT_W
   always_ff @(posedge clk) begin
      if (rst) begin
         instret_q <= '0;
      end else if (retire) begin
         instret_q <= instret_q + CNT_W'(1);
      end
   end

endmodule
